data_mem_stall: RTL and testbench
=================================

// Module: data_mem_stall
// PURPOSE
//  Parametrised word-addressed data memory for the pipelined MIPS core, MEM stage. Adds req/ready handshake with
//  fixed or pseudo-random wait states, and a write-commit trace port for the bench's "*addr <= data" log.
//  Writes byte-enable merged into the addressed word. Drop-in for the zero-latency bench memory when LATENCY=0.
// PARAMETERS
//  DEPTH_WORDS  4096      memory depth in 32-bit words (power of two)
//  BASE_ADDR    32'h0     byte address of word 0
//  LATENCY      0         max wait cycles per access (0..15)
//  STALL_MODE   0         0 = every access waits LATENCY; 1 = wait = lfsr[3:0] % (LATENCY+1)
// PORTS
//  clk             in   1   clock, all state updates on posedge
//  reset           in   1   synchronous, active-high
//  m_data_req      in   1   access request; held with all request fields until m_data_ready
//  m_data_addr     in   32  byte address; bits[1:0] ignored
//  m_data_byteen   in   4   byte write enables; 4'b0000 = read
//  m_data_wdata    in   32  write data, lane i valid when byteen[i]
//  m_inst_addr     in   32  PC of MEM-stage instruction, trace only
//  m_data_rdata    out  32  read word, valid when m_data_ready && byteen==0
//  m_data_ready    out  1   access completes this cycle
//  m_data_stall    out  1   m_data_req & ~m_data_ready, to hazard unit
//  m_data_err      out  1   with ready: address outside [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS)
//  commit_valid    out  1   registered, one-cycle pulse after each in-range write
//  commit_pc       out  32  m_inst_addr of committed write
//  commit_addr     out  32  word-aligned byte address written
//  commit_data     out  32  full merged word written
// BEHAVIOUR
//  Reset: all memory words <= 0. FSM -> IDLE. wait counter <= 0. LFSR <= 16'hACE1.
//   All outputs 0 during and after reset until a request arrives.
//  Index: idx = (m_data_addr - BASE_ADDR) >> 2. err when idx >= DEPTH_WORDS (unsigned subtraction wraps -> err).
//  FSM states: IDLE, WAIT.
//   IDLE: req=1, wait w=0 -> ready=1 same cycle, rdata combinational, write at this edge, stay IDLE.
//         req=1, w>0 -> latch addr/byteen/wdata/pc, cnt <= w-1, -> WAIT. ready=0.
//   WAIT: cnt!=0 -> cnt--. cnt==0 -> ready=1 (latched request; rdata from latched idx); write at this edge; -> IDLE.
//  Latency: request first seen in cycle T -> ready in cycle T+w. Next request accepted no earlier than T+w+1 when w>0.
//   LATENCY=0: one access per cycle, back-to-back.
//  Wait w: STALL_MODE 0 -> w=LATENCY. STALL_MODE 1 -> w=lfsr[3:0] % (LATENCY+1), sampled in IDLE.
//   LFSR: Fibonacci, taps 16,14,13,11. Advances one step on each ready cycle only.
//  Write merge: word[idx] lane i <= wdata lane i where byteen[i], else old lane kept.
//  Error handling: err=1 with ready, rdata=0, no write, no commit pulse.
//  Read same cycle as write to same word: returns pre-write value.
//  Commit: cycle after each committed write, commit_valid=1 with pc/aligned addr/merged word; else commit_valid=0.
//   Other commit_* fields hold their last value.
//  Request drops while in WAIT (protocol violation): FSM still completes the latched access. ready pulses regardless.
//  Reset asserted in WAIT: access abandoned, no write, FSM -> IDLE.
// STRUCTURE
//  Package mem_model_pkg:
//   - state enum {IDLE, WAIT}
//   - LFSR_SEED = 16'hACE1, LFSR_TAPS
//   - function merge_bytes(old, wdata, byteen)
//  Sub-module lfsr16 (clk, reset, step, q). Memory array, FSM and commit register stay in this module.
// TESTING
//  1. LATENCY=0: sw 32'h12345678 @0x10, then lw @0x10.
//     -> ready same cycle both. commit_valid next cycle with addr 0x10, data 32'h12345678. rdata = 32'h12345678.
//  2. sb byteen=4'b0100, wdata=32'h00AB0000 onto word 32'h11223344 @0x20.
//     -> commit_data = 32'h11AB3344, lw returns same.
//  3. LATENCY=3, STALL_MODE 0, lw @0x0 at cycle T.
//     -> stall=1 for T..T+2. ready at T+3. stall 0 at T+3.
//  4. Out-of-range: addr = 4*DEPTH_WORDS, byteen=4'hF.
//     -> err=1 with ready, rdata=0, no commit_valid, word 0 unchanged.
//  5. STALL_MODE 1, LATENCY=7, 100 reads.
//     -> each wait equals the reference-model LFSR sequence from seed 16'hACE1, wait always <= 7.
//  6. LATENCY=4: reset pulsed in cycle 2 of a pending sw.
//     -> no commit pulse, memory word stays 0, next request served normally.

Source files
------------

// File: rtl/data_mem_stall_pkg.sv
// Shared types, LFSR constants and the byte-lane merge helper for the MEM-stage data memory.
// Imported by lfsr16 and data_mem_stall.
// Contents: state_e, LFSR_SEED, LFSR_TAPS, merge_bytes().
package mem_model_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Right-shifting Fibonacci form: polynomial taps 16,14,13,11 sit on bits 0,2,3,5.
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  // Lane i of the result takes wdata where byteen[i] is set, otherwise keeps the old lane.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  byteen);
    logic [31:0] merged;
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (byteen[i]) merged[8*i +: 8] = wdata[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/data_mem_stall_if.sv
// Data-memory request/response bus plus the write-commit trace port.
// master: pipeline side (drives request fields); slave: memory side (drives response and commit trace).
// Signals: m_data_req/addr/byteen/wdata, m_inst_addr -> ; <- m_data_rdata/ready/stall/err, commit_*.
interface data_mem_stall_if;
  logic        m_data_req;
  logic [31:0] m_data_addr;
  logic [3:0]  m_data_byteen;
  logic [31:0] m_data_wdata;
  logic [31:0] m_inst_addr;
  logic [31:0] m_data_rdata;
  logic        m_data_ready;
  logic        m_data_stall;
  logic        m_data_err;
  logic        commit_valid;
  logic [31:0] commit_pc;
  logic [31:0] commit_addr;
  logic [31:0] commit_data;

  modport master (
    output m_data_req, m_data_addr, m_data_byteen, m_data_wdata, m_inst_addr,
    input  m_data_rdata, m_data_ready, m_data_stall, m_data_err,
    input  commit_valid, commit_pc, commit_addr, commit_data
  );

  modport slave (
    input  m_data_req, m_data_addr, m_data_byteen, m_data_wdata, m_inst_addr,
    output m_data_rdata, m_data_ready, m_data_stall, m_data_err,
    output commit_valid, commit_pc, commit_addr, commit_data
  );
endinterface

// File: rtl/data_mem_stall_lfsr16.sv
// 16-bit Fibonacci LFSR used to pick pseudo-random wait-state counts.
// Ports: clk, reset (sync, active-high, loads LFSR_SEED), step (advance one shift), q (current state).
// Holds its value whenever step is low.
module lfsr16
  import mem_model_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        step,
  output logic [15:0] q
);

  logic [15:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (step) q_d = {^(q_q & LFSR_TAPS), q_q[15:1]};
  end

  always_ff @(posedge clk) begin
    if (reset) q_q <= LFSR_SEED;
    else       q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/data_mem_stall.sv
// Word-addressed MEM-stage data memory with req/ready handshake, fixed or LFSR-driven wait states,
// byte-enable write merge and a registered write-commit trace.
// Ports: clk, reset (sync, active-high), bus (data_mem_stall_if.slave).
module data_mem_stall
  import mem_model_pkg::*;
#(
  parameter int          DEPTH_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int          LATENCY     = 0,
  parameter int          STALL_MODE  = 0
)(
  input  logic              clk,
  input  logic              reset,
  data_mem_stall_if.slave   bus
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] lat_addr_q, lat_addr_d;
  logic [3:0]  lat_byteen_q, lat_byteen_d;
  logic [31:0] lat_wdata_q, lat_wdata_d;
  logic [31:0] lat_pc_q, lat_pc_d;

  logic        commit_valid_q, commit_valid_d;
  logic [31:0] commit_pc_q, commit_pc_d;
  logic [31:0] commit_addr_q, commit_addr_d;
  logic [31:0] commit_data_q, commit_data_d;

  logic [31:0] mem_q [DEPTH_WORDS];

  logic [15:0] lfsr_q;
  logic [3:0]  wait_w;
  logic        fsm_ready, ready;

  logic [31:0] act_addr, act_wdata, act_pc;
  logic [3:0]  act_byteen;
  logic [31:0] off, word_off;
  logic        err_hit;
  logic [IDX_W-1:0] idx;
  logic [31:0] merged;
  logic        we;

  lfsr16 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .step  (ready),
    .q     (lfsr_q)
  );

  // Wait count for a request first seen in IDLE.
  always_comb begin
    if (STALL_MODE == 0) wait_w = 4'(LATENCY);
    else                 wait_w = 4'((lfsr_q & 16'h000F) % 16'(LATENCY + 1));
  end

  // While waiting, the latched request is authoritative; the live bus may have moved or dropped.
  assign act_addr   = (state_q == WAIT) ? lat_addr_q   : bus.m_data_addr;
  assign act_byteen = (state_q == WAIT) ? lat_byteen_q : bus.m_data_byteen;
  assign act_wdata  = (state_q == WAIT) ? lat_wdata_q  : bus.m_data_wdata;
  assign act_pc     = (state_q == WAIT) ? lat_pc_q     : bus.m_inst_addr;

  // Unsigned subtraction: addresses below BASE_ADDR wrap to huge offsets and land in err.
  assign off      = act_addr - BASE_ADDR;
  assign word_off = off >> 2;
  assign err_hit  = (word_off >= 32'(DEPTH_WORDS));
  assign idx      = word_off[IDX_W-1:0];
  assign merged   = merge_bytes(mem_q[idx], act_wdata, act_byteen);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    lat_addr_d   = lat_addr_q;
    lat_byteen_d = lat_byteen_q;
    lat_wdata_d  = lat_wdata_q;
    lat_pc_d     = lat_pc_q;
    fsm_ready    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.m_data_req) begin
          if (wait_w == 4'd0) begin
            fsm_ready = 1'b1;
          end else begin
            lat_addr_d   = bus.m_data_addr;
            lat_byteen_d = bus.m_data_byteen;
            lat_wdata_d  = bus.m_data_wdata;
            lat_pc_d     = bus.m_inst_addr;
            cnt_d        = wait_w - 4'd1;
            state_d      = WAIT;
          end
        end
      end
      WAIT: begin
        // Completes regardless of m_data_req so a dropped request cannot wedge the FSM.
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          fsm_ready = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Nothing completes while reset is held, so all outputs stay quiet.
  assign ready = fsm_ready & ~reset;
  assign we    = ready & ~err_hit & (act_byteen != 4'b0000);

  always_comb begin
    commit_valid_d = we;
    commit_pc_d    = commit_pc_q;
    commit_addr_d  = commit_addr_q;
    commit_data_d  = commit_data_q;
    if (we) begin
      commit_pc_d   = act_pc;
      commit_addr_d = {act_addr[31:2], 2'b00};
      commit_data_d = merged;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      lat_addr_q     <= '0;
      lat_byteen_q   <= '0;
      lat_wdata_q    <= '0;
      lat_pc_q       <= '0;
      commit_valid_q <= 1'b0;
      commit_pc_q    <= '0;
      commit_addr_q  <= '0;
      commit_data_q  <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      lat_addr_q     <= lat_addr_d;
      lat_byteen_q   <= lat_byteen_d;
      lat_wdata_q    <= lat_wdata_d;
      lat_pc_q       <= lat_pc_d;
      commit_valid_q <= commit_valid_d;
      commit_pc_q    <= commit_pc_d;
      commit_addr_q  <= commit_addr_d;
      commit_data_q  <= commit_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++) mem_q[i] <= '0;
    end else if (we) begin
      mem_q[idx] <= merged;
    end
  end

  // Read is combinational from the pre-write array, so a same-cycle write is not visible.
  assign bus.m_data_rdata = (ready && !err_hit && act_byteen == 4'b0000) ? mem_q[idx] : 32'h0;
  assign bus.m_data_ready = ready;
  assign bus.m_data_stall = bus.m_data_req & ~ready;
  assign bus.m_data_err   = ready & err_hit;
  assign bus.commit_valid = commit_valid_q;
  assign bus.commit_pc    = commit_pc_q;
  assign bus.commit_addr  = commit_addr_q;
  assign bus.commit_data  = commit_data_q;

endmodule

// File: tb/tb_data_mem_stall.sv
module tb_data_mem_stall;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Shared request drivers; only the selected instance sees req.
  int          sel = 0;
  logic        d_req = 1'b0;
  logic [3:0]  d_be = '0;
  logic [31:0] d_addr = '0, d_wdata = '0, d_pc = '0;

  data_mem_stall_if if0 ();
  data_mem_stall_if if3 ();
  data_mem_stall_if if7 ();
  data_mem_stall_if if4 ();

  assign if0.m_data_req = d_req && sel == 0;
  assign if3.m_data_req = d_req && sel == 3;
  assign if7.m_data_req = d_req && sel == 7;
  assign if4.m_data_req = d_req && sel == 4;
  assign if0.m_data_addr = d_addr;  assign if3.m_data_addr = d_addr;
  assign if7.m_data_addr = d_addr;  assign if4.m_data_addr = d_addr;
  assign if0.m_data_byteen = d_be;  assign if3.m_data_byteen = d_be;
  assign if7.m_data_byteen = d_be;  assign if4.m_data_byteen = d_be;
  assign if0.m_data_wdata = d_wdata; assign if3.m_data_wdata = d_wdata;
  assign if7.m_data_wdata = d_wdata; assign if4.m_data_wdata = d_wdata;
  assign if0.m_inst_addr = d_pc;    assign if3.m_inst_addr = d_pc;
  assign if7.m_inst_addr = d_pc;    assign if4.m_inst_addr = d_pc;

  data_mem_stall u0 (.clk(clk), .reset(rst), .bus(if0));
  data_mem_stall #(.DEPTH_WORDS(64), .LATENCY(3), .STALL_MODE(0)) u3 (.clk(clk), .reset(rst), .bus(if3));
  data_mem_stall #(.DEPTH_WORDS(64), .LATENCY(7), .STALL_MODE(1)) u7 (.clk(clk), .reset(rst), .bus(if7));
  data_mem_stall #(.DEPTH_WORDS(64), .LATENCY(4), .STALL_MODE(0)) u4 (.clk(clk), .reset(rst), .bus(if4));

  logic        s_ready, s_stall, s_err, s_cv;
  logic [31:0] s_rdata, s_cpc, s_caddr, s_cdata;
  always_comb begin
    s_ready = if0.m_data_ready; s_stall = if0.m_data_stall; s_err = if0.m_data_err;
    s_rdata = if0.m_data_rdata; s_cv = if0.commit_valid; s_cpc = if0.commit_pc;
    s_caddr = if0.commit_addr;  s_cdata = if0.commit_data;
    case (sel)
      3: begin
        s_ready = if3.m_data_ready; s_stall = if3.m_data_stall; s_err = if3.m_data_err;
        s_rdata = if3.m_data_rdata; s_cv = if3.commit_valid; s_cpc = if3.commit_pc;
        s_caddr = if3.commit_addr;  s_cdata = if3.commit_data;
      end
      7: begin
        s_ready = if7.m_data_ready; s_stall = if7.m_data_stall; s_err = if7.m_data_err;
        s_rdata = if7.m_data_rdata; s_cv = if7.commit_valid; s_cpc = if7.commit_pc;
        s_caddr = if7.commit_addr;  s_cdata = if7.commit_data;
      end
      4: begin
        s_ready = if4.m_data_ready; s_stall = if4.m_data_stall; s_err = if4.m_data_err;
        s_rdata = if4.m_data_rdata; s_cv = if4.commit_valid; s_cpc = if4.commit_pc;
        s_caddr = if4.commit_addr;  s_cdata = if4.commit_data;
      end
      default: ;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Reference LFSR, right-shift Fibonacci with taps 16,14,13,11.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

  // One access on the selected instance that must complete after exactly w wait cycles.
  task automatic acc(input string nm, input int w, input logic [3:0] be, input logic [31:0] a,
                     input logic [31:0] wd, input logic [31:0] pc, input logic [31:0] exp_rd,
                     input logic exp_commit, input logic [31:0] exp_cdata);
    @(negedge clk);
    d_req = 1'b1; d_be = be; d_addr = a; d_wdata = wd; d_pc = pc;
    for (int k = 0; k <= w; k++) begin
      #1;
      chk($sformatf("%s_stall_c%0d", nm, k), 32'(s_stall), 32'(k < w));
      chk($sformatf("%s_ready_c%0d", nm, k), 32'(s_ready), 32'(k == w));
      if (k < w) @(negedge clk);
    end
    chk({nm, "_rdata"}, s_rdata, exp_rd);
    chk({nm, "_err"}, 32'(s_err), 32'h0);
    @(posedge clk); #1;
    d_req = 1'b0;
    chk({nm, "_cv"}, 32'(s_cv), 32'(exp_commit));
    if (exp_commit) chk({nm, "_cdata"}, s_cdata, exp_cdata);
  endtask

  typedef struct {
    string       nm;
    logic [3:0]  be;
    logic [31:0] addr, wdata, pc;
    logic [31:0] rdata;
    logic        err;
    logic        cv;
    logic [31:0] caddr, cdata, cpc;
  } vec_t;

  vec_t vecs [10];
  logic [15:0] model;
  int cnt;
  int exp_w;
  int cv_seen;

  initial begin
    vecs[0] = '{"sw10",   4'hF, 32'h10,       32'h12345678, 32'h400, 32'h0,        1'b0, 1'b1, 32'h10, 32'h12345678, 32'h400};
    vecs[1] = '{"lw10",   4'h0, 32'h10,       32'h0,        32'h0,   32'h12345678, 1'b0, 1'b0, 32'h10, 32'h12345678, 32'h400};
    vecs[2] = '{"sw20",   4'hF, 32'h20,       32'h11223344, 32'h404, 32'h0,        1'b0, 1'b1, 32'h20, 32'h11223344, 32'h404};
    vecs[3] = '{"sb22",   4'h4, 32'h22,       32'h00AB0000, 32'h408, 32'h0,        1'b0, 1'b1, 32'h20, 32'h11AB3344, 32'h408};
    vecs[4] = '{"lw20",   4'h0, 32'h20,       32'h0,        32'h0,   32'h11AB3344, 1'b0, 1'b0, 32'h20, 32'h11AB3344, 32'h408};
    vecs[5] = '{"sw_oor", 4'hF, 32'h4000,     32'hDEADBEEF, 32'h40C, 32'h0,        1'b1, 1'b0, 32'h20, 32'h11AB3344, 32'h408};
    vecs[6] = '{"lw0",    4'h0, 32'h0,        32'h0,        32'h0,   32'h0,        1'b0, 1'b0, 32'h20, 32'h11AB3344, 32'h408};
    vecs[7] = '{"lw_wrap",4'h0, 32'hFFFFFFFC, 32'h0,        32'h0,   32'h0,        1'b1, 1'b0, 32'h20, 32'h11AB3344, 32'h408};
    vecs[8] = '{"sh10",   4'h3, 32'h10,       32'hFFFF5555, 32'h410, 32'h0,        1'b0, 1'b1, 32'h10, 32'h12345555, 32'h410};
    vecs[9] = '{"lw13",   4'h0, 32'h13,       32'h0,        32'h0,   32'h12345555, 1'b0, 1'b0, 32'h10, 32'h12345555, 32'h410};

    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    #1;
    chk("rst_ready", 32'(if0.m_data_ready), 32'h0);
    chk("rst_stall", 32'(if0.m_data_stall), 32'h0);
    chk("rst_cv",    32'(if0.commit_valid), 32'h0);
    chk("rst_cdata", if0.commit_data, 32'h0);
    chk("rst_rdata", if0.m_data_rdata, 32'h0);

    // Zero-latency back-to-back accesses.
    sel = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      d_req = 1'b1; d_be = vecs[i].be; d_addr = vecs[i].addr; d_wdata = vecs[i].wdata; d_pc = vecs[i].pc;
      #1;
      chk({vecs[i].nm, "_ready"}, 32'(s_ready), 32'h1);
      chk({vecs[i].nm, "_stall"}, 32'(s_stall), 32'h0);
      chk({vecs[i].nm, "_err"},   32'(s_err),   32'(vecs[i].err));
      chk({vecs[i].nm, "_rdata"}, s_rdata, vecs[i].rdata);
      @(posedge clk); #1;
      chk({vecs[i].nm, "_cv"},    32'(s_cv), 32'(vecs[i].cv));
      chk({vecs[i].nm, "_caddr"}, s_caddr, vecs[i].caddr);
      chk({vecs[i].nm, "_cdata"}, s_cdata, vecs[i].cdata);
      chk({vecs[i].nm, "_cpc"},   s_cpc,   vecs[i].cpc);
    end
    d_req = 1'b0;

    // Fixed three wait states.
    sel = 3;
    acc("l3_sw0", 3, 4'hF, 32'h0, 32'hA5A5A5A5, 32'h500, 32'h0, 1'b1, 32'hA5A5A5A5);
    acc("l3_lw0", 3, 4'h0, 32'h0, 32'h0, 32'h504, 32'hA5A5A5A5, 1'b0, 32'h0);

    // Pseudo-random waits against the reference LFSR.
    sel = 7;
    model = 16'hACE1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      d_req = 1'b1; d_be = 4'h0; d_addr = 32'(4 * (i % 64));
      cnt = 0;
      #1;
      while (!s_ready && cnt < 20) begin
        @(negedge clk); #1;
        cnt++;
      end
      exp_w = int'(model[3:0]) % 8;
      chk($sformatf("rnd_wait_%0d", i), 32'(cnt), 32'(exp_w));
      model = lfsr_next(model);
      @(posedge clk);
    end
    @(negedge clk); d_req = 1'b0;

    // Reset in the middle of a pending write.
    sel = 4;
    cv_seen = 0;
    @(negedge clk);
    d_req = 1'b1; d_be = 4'hF; d_addr = 32'h8; d_wdata = 32'hCAFEF00D; d_pc = 32'h600;
    #1; chk("rw_stall_c0", 32'(s_stall), 32'h1);
    @(negedge clk); #1; chk("rw_stall_c1", 32'(s_stall), 32'h1);
    @(negedge clk); rst = 1'b1;
    #1; chk("rw_ready_inrst", 32'(s_ready), 32'h0);
    @(negedge clk); rst = 1'b0; d_req = 1'b0;
    for (int k = 0; k < 6; k++) begin
      #1;
      if (s_cv || s_ready) cv_seen++;
      @(negedge clk);
    end
    chk("rw_no_commit", 32'(cv_seen), 32'h0);
    acc("rw_lw8",  4, 4'h0, 32'h8, 32'h0, 32'h604, 32'h0, 1'b0, 32'h0);
    acc("rw_sw8",  4, 4'hF, 32'h8, 32'h000055AA, 32'h608, 32'h0, 1'b1, 32'h000055AA);
    acc("rw_lw8b", 4, 4'h0, 32'h8, 32'h0, 32'h60C, 32'h000055AA, 1'b0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
